// File: rtl/axi_pkg.sv
// ============================================================================
// Module      : axi_pkg
// Description : Shared AXI response encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

endpackage

`default_nettype wire

// File: rtl/axi_channel.sv
// ============================================================================
// Module      : axi_channel
// Description : AXI4 channel bundle with master and slave views.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_channel #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int USER_W = 1
);

  logic                aw_valid;
  logic                aw_ready;
  logic [ID_W-1:0]     aw_id;
  logic [ADDR_W-1:0]   aw_addr;
  logic [7:0]          aw_len;
  logic [2:0]          aw_size;
  logic [1:0]          aw_burst;
  logic [2:0]          aw_prot;

  logic                w_valid;
  logic                w_ready;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_last;

  logic                b_valid;
  logic                b_ready;
  logic [ID_W-1:0]     b_id;
  logic [1:0]          b_resp;
  logic [USER_W-1:0]   b_user;

  logic                ar_valid;
  logic                ar_ready;
  logic [ID_W-1:0]     ar_id;
  logic [ADDR_W-1:0]   ar_addr;
  logic [7:0]          ar_len;
  logic [2:0]          ar_size;
  logic [1:0]          ar_burst;
  logic [2:0]          ar_prot;

  logic                r_valid;
  logic                r_ready;
  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                r_last;
  logic [USER_W-1:0]   r_user;

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_prot,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_id, b_resp, b_user,
    input  b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_prot,
    output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last, r_user,
    input  r_ready
  );

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_prot,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_id, b_resp, b_user,
    output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_prot,
    input  ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last, r_user,
    output r_ready
  );

endinterface

`default_nettype wire

// File: rtl/axi_error_slave.sv
// ============================================================================
// Module      : axi_error_slave
// Description : Terminating AXI4 slave answering every burst with RESP.
//               Optional AXI_ERROR_SLAVE_COUNT_EN adds a saturating err_count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_error_slave
  import axi_pkg::*;
#(
  parameter resp_t RESP = RESP_DECERR
) (
  input  logic        clk,
  input  logic        rstn,
  axi_channel.slave   master
`ifdef AXI_ERROR_SLAVE_COUNT_EN
  ,
  output logic [31:0] err_count
`endif
);

  localparam int ID_W = $bits(master.aw_id);

  typedef enum logic [1:0] {W_ADDR = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_e;
  typedef enum logic       {R_ADDR = 1'b0, R_DATA = 1'b1} rstate_e;

  wstate_e         wstate_q, wstate_d;
  rstate_e         rstate_q, rstate_d;
  logic [ID_W-1:0] bid_q, bid_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            rdy_en_q;

  logic aw_rdy, w_rdy, b_vld, ar_rdy, r_vld, r_lst;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, r_done;

  // Ready outputs are held low until one edge after reset release.
  assign aw_rdy = (wstate_q == W_ADDR) && rdy_en_q;
  assign w_rdy  = (wstate_q == W_DATA);
  assign b_vld  = (wstate_q == W_RESP);
  assign ar_rdy = (rstate_q == R_ADDR) && rdy_en_q;
  assign r_vld  = (rstate_q == R_DATA);
  assign r_lst  = r_vld && (cnt_q == 8'd0);

  assign aw_hs  = master.aw_valid && aw_rdy;
  assign w_hs   = master.w_valid  && w_rdy;
  assign b_hs   = master.b_ready  && b_vld;
  assign ar_hs  = master.ar_valid && ar_rdy;
  assign r_hs   = master.r_ready  && r_vld;
  assign r_done = r_hs && r_lst;

  assign master.aw_ready = aw_rdy;
  assign master.w_ready  = w_rdy;
  assign master.b_valid  = b_vld;
  assign master.b_id     = bid_q;
  assign master.b_resp   = b_vld ? RESP : 2'b00;
  assign master.b_user   = '0;
  assign master.ar_ready = ar_rdy;
  assign master.r_valid  = r_vld;
  assign master.r_id     = rid_q;
  assign master.r_data   = '0;
  assign master.r_resp   = r_vld ? RESP : 2'b00;
  assign master.r_last   = r_lst;
  assign master.r_user   = '0;

  always_comb begin
    wstate_d = wstate_q;
    bid_d    = bid_q;
    case (wstate_q)
      W_ADDR: if (aw_hs) begin
        bid_d    = master.aw_id;
        wstate_d = W_DATA;
      end
      W_DATA: if (w_hs && master.w_last) wstate_d = W_RESP;
      W_RESP: if (b_hs) wstate_d = W_ADDR;
      default: wstate_d = W_ADDR;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    rid_d    = rid_q;
    cnt_d    = cnt_q;
    case (rstate_q)
      R_ADDR: if (ar_hs) begin
        rid_d    = master.ar_id;
        cnt_d    = master.ar_len;
        rstate_d = R_DATA;
      end
      R_DATA: if (r_hs) begin
        if (cnt_q == 8'd0) rstate_d = R_ADDR;
        else               cnt_d    = cnt_q - 8'd1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wstate_q <= W_ADDR;
      rstate_q <= R_ADDR;
      bid_q    <= '0;
      rid_q    <= '0;
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      bid_q    <= bid_d;
      rid_q    <= rid_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= 1'b1;
    end
  end

`ifdef AXI_ERROR_SLAVE_COUNT_EN
  logic [31:0] err_q;
  logic [1:0]  err_inc;
  logic [32:0] err_sum;

  // B and R-last can complete together, so the step is 0, 1 or 2.
  assign err_inc = {1'b0, b_hs} + {1'b0, r_done};
  assign err_sum = {1'b0, err_q} + {31'd0, err_inc};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_q <= '0;
    else       err_q <= err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
  end

  assign err_count = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_error_slave.sv
// ============================================================================
// Module      : tb_axi_error_slave
// Description : Self-checking bench for axi_error_slave (random bursts/stalls).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_error_slave;

  localparam int         ID_W     = 4;
  localparam int         DATA_W   = 32;
  localparam logic [1:0] EXP_RESP = 2'b11;
  localparam int         BUDGET   = 3000;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;

  axi_channel #(.ID_W(ID_W), .DATA_W(DATA_W)) m_if ();

`ifdef AXI_ERROR_SLAVE_COUNT_EN
  logic [31:0] err_count;
`endif

  axi_error_slave dut (
    .clk       (clk),
    .rstn      (rstn),
    .master    (m_if)
`ifdef AXI_ERROR_SLAVE_COUNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic init_inputs();
    m_if.aw_valid = 0; m_if.aw_id = '0; m_if.aw_addr = '0; m_if.aw_len = '0;
    m_if.aw_size = '0; m_if.aw_burst = '0; m_if.aw_prot = '0;
    m_if.w_valid = 0; m_if.w_data = '0; m_if.w_strb = '0; m_if.w_last = 0;
    m_if.b_ready = 0;
    m_if.ar_valid = 0; m_if.ar_id = '0; m_if.ar_addr = '0; m_if.ar_len = '0;
    m_if.ar_size = '0; m_if.ar_burst = '0; m_if.ar_prot = '0;
    m_if.r_ready = 0;
  endtask

  function automatic logic [8:0] out_vec();
    return {m_if.aw_ready, m_if.w_ready, m_if.b_valid, m_if.b_resp,
            m_if.ar_ready, m_if.r_valid, m_if.r_last, m_if.r_resp[0] | m_if.r_resp[1]};
  endfunction

  task automatic test_reset();
    init_inputs();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_vec() !== 9'b0) begin
      n_fail++; $display("FAIL reset_outputs actual=%b required=%b", out_vec(), 9'b0);
    end
    rstn = 1'b1;
    #1;
    n_checks++;
    if ({m_if.aw_ready, m_if.ar_ready} !== 2'b00) begin
      n_fail++; $display("FAIL ready_before_edge actual=%b required=00", {m_if.aw_ready, m_if.ar_ready});
    end
    @(negedge clk);
    n_checks++;
    if ({m_if.aw_ready, m_if.ar_ready, m_if.w_ready, m_if.b_valid, m_if.r_valid} !== 5'b11000) begin
      n_fail++; $display("FAIL ready_after_release actual=%b required=11000",
                         {m_if.aw_ready, m_if.ar_ready, m_if.w_ready, m_if.b_valid, m_if.r_valid});
    end
`ifdef AXI_ERROR_SLAVE_COUNT_EN
    n_checks++;
    if (err_count !== 32'd0) begin
      n_fail++; $display("FAIL err_count_reset actual=%0d required=0", err_count);
    end
`endif
    exp_cnt = 0;
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [ID_W-1:0] id, input int beats, input int aw_delay,
                          input int b_stall_pct, input bit early_w);
    int phase = 0;  // 0 await AW, 1 data, 2 response, 3 done
    int wsent = 0;
    int cyc   = 0;
    bit aw_hs, w_hs, b_hs;
    m_if.w_valid = early_w;
    m_if.w_last  = (beats == 1);
    m_if.b_ready = 0;
    while (phase != 3 && cyc < BUDGET) begin
      if (phase == 0 && cyc >= aw_delay) begin
        m_if.aw_valid = 1; m_if.aw_id = id; m_if.aw_len = 8'($urandom);
        m_if.aw_addr = $urandom;
      end
      if (phase == 1) begin
        m_if.w_valid = ($urandom_range(3) != 0);
        m_if.w_last  = (wsent == beats - 1);
        m_if.w_data  = $urandom;
      end
      if (phase == 2) m_if.b_ready = ($urandom_range(99) >= b_stall_pct);
      @(negedge clk);
      n_checks++;
      if ({m_if.aw_ready, m_if.w_ready, m_if.b_valid} !== {phase == 0, phase == 1, phase == 2}) begin
        n_fail++; $display("FAIL write_ctrl id=%0d aw/w/b actual=%b required=%b", id,
                           {m_if.aw_ready, m_if.w_ready, m_if.b_valid}, {phase == 0, phase == 1, phase == 2});
      end
      if (phase == 2) begin
        n_checks++;
        if (m_if.b_id !== id || m_if.b_resp !== EXP_RESP || m_if.b_user !== 1'b0) begin
          n_fail++; $display("FAIL write_resp id/resp/user actual=%0d/%b/%b required=%0d/%b/0",
                             m_if.b_id, m_if.b_resp, m_if.b_user, id, EXP_RESP);
        end
      end
      aw_hs = m_if.aw_valid && m_if.aw_ready;
      w_hs  = m_if.w_valid && m_if.w_ready;
      b_hs  = m_if.b_valid && m_if.b_ready;
      @(posedge clk); #1;
      cyc++;
      if (aw_hs) begin m_if.aw_valid = 0; phase = 1; end
      if (w_hs) begin
        wsent++;
        if (wsent == beats) begin phase = 2; m_if.w_valid = 0; m_if.w_last = 0; end
      end
      if (b_hs) begin phase = 3; m_if.b_ready = 0; exp_cnt++; end
    end
    n_checks++;
    if (phase != 3) begin
      n_fail++; $display("FAIL write_timeout id=%0d actual phase=%0d required=3", id, phase);
      init_inputs();
    end else begin
      @(negedge clk);
      n_checks++;
      if ({m_if.aw_ready, m_if.b_valid} !== 2'b10) begin
        n_fail++; $display("FAIL write_idle actual aw/b=%b required=10", {m_if.aw_ready, m_if.b_valid});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_read(input logic [ID_W-1:0] id, input int len, input int ar_delay,
                         input int r_stall_pct);
    int phase = 0;  // 0 await AR, 1 data, 2 done
    int left  = 0;
    int got   = 0;
    int cyc   = 0;
    bit ar_hs, r_hs;
    m_if.r_ready = 0;
    while (phase != 2 && cyc < BUDGET) begin
      if (phase == 0 && cyc >= ar_delay) begin
        m_if.ar_valid = 1; m_if.ar_id = id; m_if.ar_len = 8'(len); m_if.ar_addr = $urandom;
      end
      if (phase == 1) m_if.r_ready = ($urandom_range(99) >= r_stall_pct);
      @(negedge clk);
      n_checks++;
      if ({m_if.ar_ready, m_if.r_valid} !== {phase == 0, phase == 1}) begin
        n_fail++; $display("FAIL read_ctrl id=%0d ar/r actual=%b required=%b", id,
                           {m_if.ar_ready, m_if.r_valid}, {phase == 0, phase == 1});
      end
      if (phase == 1) begin
        n_checks++;
        if (m_if.r_id !== id || m_if.r_data !== {DATA_W{1'b0}} || m_if.r_resp !== EXP_RESP ||
            m_if.r_last !== (left == 1) || m_if.r_user !== 1'b0) begin
          n_fail++; $display("FAIL read_beat id/data/resp/last actual=%0d/%h/%b/%b required=%0d/0/%b/%b",
                             m_if.r_id, m_if.r_data, m_if.r_resp, m_if.r_last, id, EXP_RESP, left == 1);
        end
      end
      ar_hs = m_if.ar_valid && m_if.ar_ready;
      r_hs  = m_if.r_valid && m_if.r_ready;
      @(posedge clk); #1;
      cyc++;
      if (ar_hs) begin m_if.ar_valid = 0; phase = 1; left = len + 1; end
      if (r_hs) begin
        got++; left--;
        if (left == 0) begin phase = 2; m_if.r_ready = 0; exp_cnt++; end
      end
    end
    n_checks++;
    if (phase != 2 || got != len + 1) begin
      n_fail++; $display("FAIL read_beats id=%0d actual=%0d required=%0d", id, got, len + 1);
      init_inputs();
    end else begin
      @(negedge clk);
      n_checks++;
      if ({m_if.ar_ready, m_if.r_valid} !== 2'b10) begin
        n_fail++; $display("FAIL read_idle actual ar/r=%b required=10", {m_if.ar_ready, m_if.r_valid});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_simultaneous();
    m_if.aw_valid = 1; m_if.aw_id = 4'd2;
    m_if.ar_valid = 1; m_if.ar_id = 4'd6; m_if.ar_len = 8'd0;
    m_if.w_valid = 1; m_if.w_last = 1;
    m_if.b_ready = 0; m_if.r_ready = 0;
    @(negedge clk);
    n_checks++;
    if ({m_if.aw_ready, m_if.ar_ready} !== 2'b11) begin
      n_fail++; $display("FAIL sim_addr actual=%b required=11", {m_if.aw_ready, m_if.ar_ready});
    end
    @(posedge clk); #1;
    m_if.aw_valid = 0; m_if.ar_valid = 0;
    @(negedge clk);
    n_checks++;
    if ({m_if.w_ready, m_if.r_valid, m_if.r_last} !== 3'b111) begin
      n_fail++; $display("FAIL sim_data actual=%b required=111", {m_if.w_ready, m_if.r_valid, m_if.r_last});
    end
    @(posedge clk); #1;
    m_if.w_valid = 0; m_if.w_last = 0;
    @(negedge clk);
    n_checks++;
    if ({m_if.b_valid, m_if.r_valid, m_if.b_id, m_if.r_id} !== {2'b11, 4'd2, 4'd6}) begin
      n_fail++; $display("FAIL sim_resp actual=%b required=%b",
                         {m_if.b_valid, m_if.r_valid, m_if.b_id, m_if.r_id}, {2'b11, 4'd2, 4'd6});
    end
`ifdef AXI_ERROR_SLAVE_COUNT_EN
    n_checks++;
    if (err_count !== 32'(exp_cnt)) begin
      n_fail++; $display("FAIL sim_count_before actual=%0d required=%0d", err_count, exp_cnt);
    end
`endif
    m_if.b_ready = 1; m_if.r_ready = 1;
    @(posedge clk); #1;
    m_if.b_ready = 0; m_if.r_ready = 0;
    exp_cnt += 2;
    @(negedge clk);
    n_checks++;
    if ({m_if.b_valid, m_if.r_valid, m_if.aw_ready, m_if.ar_ready} !== 4'b0011) begin
      n_fail++; $display("FAIL sim_done actual=%b required=0011",
                         {m_if.b_valid, m_if.r_valid, m_if.aw_ready, m_if.ar_ready});
    end
`ifdef AXI_ERROR_SLAVE_COUNT_EN
    n_checks++;
    if (err_count !== 32'(exp_cnt)) begin
      n_fail++; $display("FAIL sim_count_after actual=%0d required=%0d", err_count, exp_cnt);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_read();
    m_if.ar_valid = 1; m_if.ar_id = 4'd9; m_if.ar_len = 8'd3; m_if.r_ready = 1;
    @(posedge clk); #1;
    m_if.ar_valid = 0;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({m_if.r_valid, m_if.r_last} !== 2'b10) begin
      n_fail++; $display("FAIL midread_beat2 actual=%b required=10", {m_if.r_valid, m_if.r_last});
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if (out_vec() !== 9'b0) begin
      n_fail++; $display("FAIL midread_reset actual=%b required=%b", out_vec(), 9'b0);
    end
    exp_cnt = 0;
    m_if.r_ready = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({m_if.ar_ready, m_if.r_valid} !== 2'b10) begin
      n_fail++; $display("FAIL midread_release actual=%b required=10", {m_if.ar_ready, m_if.r_valid});
    end
    @(posedge clk); #1;
    do_read(4'd4, 3, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      fork
        do_write(4'($urandom), $urandom_range(1, 6), $urandom_range(0, 3), 40, 1'($urandom_range(1)));
        do_read(4'($urandom), (i == 10) ? 255 : $urandom_range(0, 15), $urandom_range(0, 3), 40);
      join
    end
  endtask

  task automatic test_count();
`ifdef AXI_ERROR_SLAVE_COUNT_EN
    @(negedge clk);
    n_checks++;
    if (err_count !== 32'(exp_cnt)) begin
      n_fail++; $display("FAIL err_count_total actual=%0d required=%0d", err_count, exp_cnt);
    end
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    do_write(4'd5, 1, 0, 0, 1'b0);
    do_read(4'd3, 3, 0, 0);
    do_read(4'($urandom), 7, 0, 50);
    do_write(4'd11, 2, 4, 30, 1'b1);
    do_read(4'd1, 0, 0, 0);
    test_reset_mid_read();
    test_random();
    test_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
